// File: rtl/vga_timing_controller.sv
// Horizontal-sync sequencer and vertical line counter for the pong VGA display.
// Optional FrameCount output is enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_controller #(
   parameter int xresolution = 10,
   parameter int yresolution = 10,
   parameter int CLKDIV      = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   Enable,
   input  logic                   ModeSelect,
   input  logic                   ModeLoad,
   input  logic                   LineEnd,
   output logic                   PixelClock,
   output logic                   HsyncReset,
   output logic [xresolution-1:0] SynchPulse,
   output logic [xresolution-1:0] FrontPorch,
   output logic [xresolution-1:0] ActiveVideo,
   output logic [xresolution-1:0] BackPorch,
   output logic                   vsync,
   output logic [yresolution-1:0] yposition,
   output logic                   FrameEnd,
   output logic                   ModeActive,
   output logic                   Busy
`ifdef VGA_FRAME_COUNT_EN
   ,
   output logic [7:0]             FrameCount
`endif
);

   localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

   localparam logic [yresolution-1:0] VS_START0 = yresolution'(480 + 10);
   localparam logic [yresolution-1:0] VS_STOP0  = yresolution'(480 + 10 + 2);
   localparam logic [yresolution-1:0] VEND0     = yresolution'(480 + 10 + 2 + 33);
   localparam logic [yresolution-1:0] VS_START1 = yresolution'(8 + 1);
   localparam logic [yresolution-1:0] VS_STOP1  = yresolution'(8 + 1 + 2);
   localparam logic [yresolution-1:0] VEND1     = yresolution'(8 + 1 + 2 + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                 state;
   state_t                 next_state;
   logic                   pend_mode;
   logic                   pend_flag;
   logic                   pend_seen;
   logic                   line_d;
   logic                   sw_pulse;
   logic [DIV_W-1:0]       div_cnt;
   logic                   apply_mode;
   logic                   restart_div;
   logic                   new_mode;
   logic                   running;
   logic                   line_edge;
   logic                   frame_wrap;
   logic [yresolution-1:0] vend;
   logic [yresolution-1:0] vs_start;
   logic [yresolution-1:0] vs_stop;
   logic [yresolution-1:0] y_next;

   function automatic logic in_sync(input logic [yresolution-1:0] y,
                                    input logic [yresolution-1:0] lo,
                                    input logic [yresolution-1:0] hi);
      return (y >= lo) && (y < hi);
   endfunction

   always_comb begin
      if (ModeActive) begin
         SynchPulse  = xresolution'(4);
         FrontPorch  = xresolution'(2);
         ActiveVideo = xresolution'(16);
         BackPorch   = xresolution'(2);
         vend        = VEND1;
         vs_start    = VS_START1;
         vs_stop     = VS_STOP1;
      end else begin
         SynchPulse  = xresolution'(96);
         FrontPorch  = xresolution'(16);
         ActiveVideo = xresolution'(640);
         BackPorch   = xresolution'(48);
         vend        = VEND0;
         vs_start    = VS_START0;
         vs_stop     = VS_STOP0;
      end
   end

   assign running    = (state != IDLE);
   assign line_edge  = LineEnd & ~line_d;
   assign frame_wrap = running && line_edge && (yposition == vend);
   assign y_next     = frame_wrap ? '0 : yposition + yresolution'(1);
   // A ModeLoad landing on the boundary clock wins over the older pending value.
   assign new_mode   = ModeLoad ? ModeSelect : pend_mode;
   assign Busy       = running;
   assign HsyncReset = (state == IDLE) | sw_pulse;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      apply_mode  = 1'b0;
      restart_div = 1'b0;
      case (state)
         IDLE: begin
            if (Enable) begin
               next_state = RUN;
               apply_mode = 1'b1;
            end
         end
         RUN: begin
            if (!Enable || pend_flag) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (frame_wrap) begin
               if (!Enable) begin
                  next_state = IDLE;
               end else begin
                  next_state  = RUN;
                  apply_mode  = 1'b1;
                  restart_div = 1'b1;
               end
            end else if (Enable && !pend_flag && pend_seen) begin
               // Mode request was withdrawn before the boundary.
               next_state = RUN;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ModeActive <= 1'b0;
         pend_mode  <= 1'b0;
         pend_flag  <= 1'b0;
         pend_seen  <= 1'b0;
         line_d     <= 1'b0;
         sw_pulse   <= 1'b0;
         div_cnt    <= '0;
         PixelClock <= 1'b0;
         yposition  <= '0;
         vsync      <= 1'b1;
         FrameEnd   <= 1'b0;
      end else begin
         line_d    <= LineEnd;
         FrameEnd  <= frame_wrap;
         sw_pulse  <= restart_div && (new_mode != ModeActive);
         pend_seen <= (next_state == DRAIN) && (pend_seen || pend_flag);

         if (apply_mode) begin
            ModeActive <= new_mode;
            pend_mode  <= new_mode;
            pend_flag  <= 1'b0;
         end else if (ModeLoad) begin
            pend_mode <= ModeSelect;
            pend_flag <= (ModeSelect != ModeActive);
         end

         if (!running || next_state == IDLE || restart_div) begin
            div_cnt    <= '0;
            PixelClock <= 1'b0;
         end else if (div_cnt == DIV_LAST) begin
            div_cnt    <= '0;
            PixelClock <= ~PixelClock;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end

         if (!running || next_state == IDLE) begin
            yposition <= '0;
            vsync     <= 1'b1;
         end else if (line_edge) begin
            yposition <= y_next;
            vsync     <= ~in_sync(y_next, vs_start, vs_stop);
         end
      end
   end

`ifdef VGA_FRAME_COUNT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         FrameCount <= 8'd0;
      end else if (running && next_state == IDLE) begin
         FrameCount <= 8'd0;
      end else if (frame_wrap) begin
         FrameCount <= FrameCount + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_controller.sv
// Randomized bench for vga_timing_controller: line-level reference model of
// the vertical counter, mode table and run/stop behaviour.
module tb_vga_timing_controller;

   localparam int XW = 10;
   localparam int YW = 10;
   localparam int CD = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          Enable = 1'b0;
   logic          ModeSelect = 1'b0;
   logic          ModeLoad = 1'b0;
   logic          LineEnd = 1'b0;
   logic          PixelClock;
   logic          HsyncReset;
   logic [XW-1:0] SynchPulse;
   logic [XW-1:0] FrontPorch;
   logic [XW-1:0] ActiveVideo;
   logic [XW-1:0] BackPorch;
   logic          vsync;
   logic [YW-1:0] yposition;
   logic          FrameEnd;
   logic          ModeActive;
   logic          Busy;
`ifdef VGA_FRAME_COUNT_EN
   logic [7:0]    FrameCount;
`endif

   vga_timing_controller #(.xresolution(XW), .yresolution(YW), .CLKDIV(CD)) dut (
      .clock(clock), .reset(reset), .Enable(Enable), .ModeSelect(ModeSelect),
      .ModeLoad(ModeLoad), .LineEnd(LineEnd), .PixelClock(PixelClock),
      .HsyncReset(HsyncReset), .SynchPulse(SynchPulse), .FrontPorch(FrontPorch),
      .ActiveVideo(ActiveVideo), .BackPorch(BackPorch), .vsync(vsync),
      .yposition(yposition), .FrameEnd(FrameEnd), .ModeActive(ModeActive),
`ifdef VGA_FRAME_COUNT_EN
      .FrameCount(FrameCount),
`endif
      .Busy(Busy)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Mode tables, index 0 = 640x480, 1 = small mode
   int h_sync[2] = '{96, 4};
   int h_front[2] = '{16, 2};
   int h_act[2] = '{640, 16};
   int h_back[2] = '{48, 2};
   int v_act[2] = '{480, 8};
   int v_front[2] = '{10, 1};
   int v_sync[2] = '{2, 2};
   int v_back[2] = '{33, 1};

   int   m_y;
   logic m_mode;
   logic m_pend;
   logic m_en;
   logic m_busy;

   function automatic int vend(input logic m);
      return v_act[m] + v_front[m] + v_sync[m] + v_back[m];
   endfunction

   function automatic logic exp_vsync(input logic m, input int y);
      int s;
      s = v_act[m] + v_front[m];
      return !((y >= s) && (y < s + v_sync[m]));
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One LineEnd rising edge of random width, checked against the model.
   task automatic line_pulse();
      int   hi;
      int   lo;
      logic wrap;
      logic sw;
      logic old;
      hi = $urandom_range(1, 3);
      lo = $urandom_range(1, 2);
      wrap = 1'b0;
      sw = 1'b0;
      LineEnd = 1'b1;
      step();
      if (m_busy) begin
         if (m_y == vend(m_mode)) begin
            wrap = 1'b1;
            m_y = 0;
            old = m_mode;
            if (m_en) begin
               m_mode = m_pend;
               sw = (old != m_mode);
            end else begin
               m_busy = 1'b0;
            end
         end else begin
            m_y = m_y + 1;
         end
      end
      checks++;
      if (int'(yposition) !== m_y) begin
         errors++;
         $display("FAIL ypos: got %0d expected %0d", yposition, m_y);
      end
      checks++;
      if (FrameEnd !== wrap) begin
         errors++;
         $display("FAIL frame_end at y=%0d: got %0b expected %0b", m_y, FrameEnd, wrap);
      end
      checks++;
      if (vsync !== exp_vsync(m_mode, m_y)) begin
         errors++;
         $display("FAIL vsync at y=%0d: got %0b expected %0b", m_y, vsync, exp_vsync(m_mode, m_y));
      end
      checks++;
      if (ModeActive !== m_mode) begin
         errors++;
         $display("FAIL mode_active: got %0b expected %0b", ModeActive, m_mode);
      end
      checks++;
      if (int'(SynchPulse) !== h_sync[m_mode] || int'(ActiveVideo) !== h_act[m_mode] ||
          int'(FrontPorch) !== h_front[m_mode] || int'(BackPorch) !== h_back[m_mode]) begin
         errors++;
         $display("FAIL hfields: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                  ActiveVideo, FrontPorch, SynchPulse, BackPorch,
                  h_act[m_mode], h_front[m_mode], h_sync[m_mode], h_back[m_mode]);
      end
      checks++;
      if (Busy !== m_busy) begin
         errors++;
         $display("FAIL busy: got %0b expected %0b", Busy, m_busy);
      end
      checks++;
      if (HsyncReset !== (!m_busy || sw)) begin
         errors++;
         $display("FAIL hsync_reset: got %0b expected %0b", HsyncReset, (!m_busy || sw));
      end
      LineEnd = (hi > 1);
      step();
      if (sw) begin
         checks++;
         if (HsyncReset !== 1'b0) begin
            errors++;
            $display("FAIL hsync_reset_pulse_len: got %0b expected 0", HsyncReset);
         end
      end
      for (int i = 2; i < hi; i++) step();
      LineEnd = 1'b0;
      for (int i = 0; i < lo; i++) step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
      m_y = 0; m_mode = 1'b0; m_pend = 1'b0; m_en = 1'b0; m_busy = 1'b0;
      checks++;
      if ({HsyncReset, PixelClock, vsync, FrameEnd, Busy, ModeActive} !== 6'b101000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 101000",
                  {HsyncReset, PixelClock, vsync, FrameEnd, Busy, ModeActive});
      end
      checks++;
      if (yposition !== '0) begin
         errors++;
         $display("FAIL reset_ypos: got %0d expected 0", yposition);
      end
      checks++;
      if (SynchPulse !== 10'd96 || ActiveVideo !== 10'd640 ||
          FrontPorch !== 10'd16 || BackPorch !== 10'd48) begin
         errors++;
         $display("FAIL reset_fields: got %0d/%0d/%0d/%0d expected 96/640/16/48",
                  SynchPulse, ActiveVideo, FrontPorch, BackPorch);
      end
   endtask

   task automatic test_start();
      int exp_pc;
      Enable = 1'b1;
      m_en = 1'b1;
      step();
      m_busy = 1'b1; m_mode = m_pend; m_y = 0;
      checks++;
      if (HsyncReset !== 1'b0 || Busy !== 1'b1) begin
         errors++;
         $display("FAIL start: got hrst=%0b busy=%0b expected hrst=0 busy=1", HsyncReset, Busy);
      end
      for (int j = 0; j < 9; j++) begin
         exp_pc = (j / CD) % 2;
         checks++;
         if (int'(PixelClock) !== exp_pc) begin
            errors++;
            $display("FAIL pixel_clock cycle %0d: got %0b expected %0d", j, PixelClock, exp_pc);
         end
         step();
      end
   endtask

   task automatic test_frame_mode0();
      for (int n = 0; n < 526; n++) line_pulse();
   endtask

   task automatic test_held_line();
      LineEnd = 1'b1;
      repeat (12) step();
      m_y = m_y + 1;
      LineEnd = 1'b0;
      step();
      checks++;
      if (int'(yposition) !== m_y) begin
         errors++;
         $display("FAIL held_line: got %0d expected %0d", yposition, m_y);
      end
   endtask

   task automatic test_mode_switch();
      ModeSelect = 1'b1;
      ModeLoad = 1'b1;
      step();
      ModeLoad = 1'b0;
      ModeSelect = 1'($urandom_range(0, 1));
      m_pend = 1'b1;
      checks++;
      if (SynchPulse !== 10'd96 || ModeActive !== 1'b0) begin
         errors++;
         $display("FAIL early_switch: got sync=%0d mode=%0b expected 96/0", SynchPulse, ModeActive);
      end
      repeat (530) if (m_mode == 1'b0) line_pulse();
      repeat (13) line_pulse();
   endtask

   task automatic test_disable();
      repeat (12) if (m_y != 5) line_pulse();
      Enable = 1'b0;
      m_en = 1'b0;
      step();
      repeat (20) if (m_busy) line_pulse();
      for (int j = 0; j < 4; j++) begin
         checks++;
         if ({PixelClock, HsyncReset, Busy} !== 3'b010) begin
            errors++;
            $display("FAIL idle_outputs: got pclk/hrst/busy=%b expected 010",
                     {PixelClock, HsyncReset, Busy});
         end
         step();
      end
      line_pulse();
      line_pulse();
   endtask

   task automatic test_reset_mid();
      Enable = 1'b1;
      m_en = 1'b1;
      step();
      m_busy = 1'b1; m_mode = m_pend; m_y = 0;
      repeat (12) if (m_y != 7) line_pulse();
      Enable = 1'b0;
      step();
      reset = 1'b1;
      step();
      checks++;
      if ({HsyncReset, PixelClock, vsync, FrameEnd, Busy, ModeActive} !== 6'b101000 ||
          yposition !== '0 || SynchPulse !== 10'd96) begin
         errors++;
         $display("FAIL reset_mid: got ctrl=%b y=%0d sync=%0d expected 101000/0/96",
                  {HsyncReset, PixelClock, vsync, FrameEnd, Busy, ModeActive}, yposition, SynchPulse);
      end
      reset = 1'b0;
      m_mode = 1'b0; m_pend = 1'b0; m_busy = 1'b0; m_y = 0; m_en = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      logic fin;
      Enable = 1'b1;
      m_en = 1'b1;
      step();
      m_busy = 1'b1; m_mode = m_pend; m_y = 0;
      line_pulse();
      fin = 1'($urandom_range(0, 1));
      ModeLoad = 1'b1;
      ModeSelect = 1'b1;
      step();
      ModeSelect = 1'b0;
      step();
      ModeSelect = fin;
      step();
      ModeLoad = 1'b0;
      m_pend = fin;
      repeat (526) line_pulse();
      repeat (3) line_pulse();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_start();
      test_frame_mode0();
      test_held_line();
      test_mode_switch();
      test_disable();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
Timing sequencer and configurator for the horizontal sync datapath of the pong VGA display.
- Generates PixelClock for the horizontal sync module.
- Supplies its four horizontal timing fields and holds its reset while stopped.
- Counts lines from the LineEnd handshake to produce vsync, yposition and FrameEnd.
- Switches video mode only at frame boundaries, so the display never sees a torn frame.

Parameters:
xresolution, 10, width of horizontal timing fields
yresolution, 10, width of vertical timing fields and yposition
CLKDIV, 2, system clocks per PixelClock half-period (PixelClock period = 2*CLKDIV clocks)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
Enable  input  1  level; 1 = run video timing, 0 = stop at next frame boundary
ModeSelect  input  1  requested mode: 0 = 640x480, 1 = small simulation mode
ModeLoad  input  1  one-clock strobe; latches ModeSelect as pending mode
LineEnd  input  1  level from the horizontal sync module; may stay high several clocks
PixelClock  output  1  pixel reference clock to the horizontal sync module
HsyncReset  output  1  reset to the horizontal sync module; high while not running
SynchPulse, FrontPorch, ActiveVideo, BackPorch  output  xresolution each  horizontal fields of the active mode
vsync  output  1  active-low vertical sync
yposition  output  yresolution  current line number
FrameEnd  output  1  one-clock pulse at frame wrap
ModeActive  output  1  currently applied mode
Busy  output  1  1 while in RUN or DRAIN

Behaviour:
Reset values:
- State IDLE, PixelClock=0, HsyncReset=1, yposition=0, vsync=1, FrameEnd=0, Busy=0.
- ModeActive=0, pending mode=0, horizontal fields = mode 0 values.

Mode table:
- Mode 0: H active 640, front 16, sync 96, back 48; V active 480, front 10, sync 2, back 33.
- Mode 1: H active 16, front 2, sync 4, back 2; V active 8, front 1, sync 2, back 1.
- VEnd = Vactive+Vfront+Vsync+Vback: 525 in mode 0, 12 in mode 1.
- Sums are computed at full field width; no truncation for the defaults.

Horizontal fields:
- Driven from registered ModeActive.
- Change only on the clock ModeActive updates.

PixelClock:
- Divider counter runs only in RUN and DRAIN.
- Toggles every CLKDIV clocks; first rising edge CLKDIV clocks after entering RUN.
- Forced 0 in IDLE and when the divider is cleared.

LineEnd handshake:
- Registered edge detect; one line is counted per 0->1 transition of LineEnd.
- A level held high counts once.
- LineEnd is ignored in IDLE.

Vertical counter (on each counted line edge):
- If yposition==VEnd: yposition<=0, FrameEnd pulses 1 clock.
- Otherwise yposition increments.
- vsync=0 exactly while Vactive+Vfront <= yposition < Vactive+Vfront+Vsync (registered, updated with yposition).

Pending mode:
- ModeLoad captures ModeSelect; a later ModeLoad overwrites an earlier one.
- A pending flag sets when the captured value differs from ModeActive.

FSM:
- IDLE: HsyncReset=1, divider cleared, yposition=0. If Enable=1: ModeActive<=pending mode, pending flag cleared, go RUN the next clock.
- RUN: HsyncReset=0. If Enable=0 or pending flag set: go DRAIN.
- DRAIN: timing continues unchanged. On FrameEnd:
  - If Enable=0: go IDLE.
  - Otherwise: ModeActive<=pending mode, clear pending flag, yposition already 0, divider restarted, go RUN.
  - HsyncReset pulses for 1 clock on a mode switch.
- DRAIN back to RUN without FrameEnd: only if Enable=1 and the pending flag has cleared because ModeLoad restored the current mode.

Simultaneous events:
- ModeLoad on the same clock as FrameEnd-in-DRAIN: the new value takes effect at that boundary.

Reset mid-frame:
- Returns everything to reset values on the next edge, regardless of state.

Optional Feature:
Macro VGA_FRAME_COUNT_EN.
- Defined: adds output FrameCount[7:0]. Reset 0; increments on each FrameEnd; wraps 255->0; cleared on entry to IDLE.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. reset, then Enable=1 with mode 0 -> HsyncReset falls 1 clock later; PixelClock period 4 clocks; SynchPulse=96, ActiveVideo=640.
2. Mode 0 running, bench drives 525 single-clock LineEnd pulses plus one more -> yposition reaches 525 then wraps to 0; FrameEnd pulses once; vsync low only for yposition 490..491.
3. LineEnd held high 12 clocks -> yposition increments exactly once.
4. Mid-frame ModeLoad with ModeSelect=1 -> fields stay 640/16/96/48 until FrameEnd, then 16/2/4/2; HsyncReset pulses 1 clock; vertical wrap now at 12.
5. Enable=0 at yposition 5 in mode 1 -> timing continues through yposition 12, then FrameEnd, IDLE, PixelClock=0, HsyncReset=1, Busy=0.
6. reset asserted at yposition 7 in DRAIN -> next clock all outputs at reset values, ModeActive=0.
